cpu_ctrl: RTL and testbench

Multicycle control unit sitting directly upstream of the 4-bit datapath (register file + ALU). Accepts 16-bit instructions from instruction memory over a valid/ready handshake. Decodes each instruction into register addresses, ALU controls (`alu_op`, `binv`, `cin`) and the register-file `rw` strobe. Sequences every instruction through FETCH, DECODE, EXEC and WB states and pulses `pc_inc` to advance the program counter.

---
 rtl/cpu_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multicycle control unit for the 4-bit register-file + ALU datapath.
//
// Accepts 16-bit instructions over a valid/ready handshake and steps each one
// through FETCH -> DECODE -> EXEC -> WB (or HALT). Decoded controls come from
// the registered instruction word, so they are stable from DECODE through WB.
//
// Optional feature: define CPU_CTRL_PERF_EN to build the retired-instruction
// counter. Without it, o_retired_cnt is tied to zero.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   i_instr_valid  instruction memory presents a valid word
//   i_instr        instruction word (sampled only on acceptance)
//   o_instr_ready  ready to accept (FETCH only, low while rst is high)
//   o_pc_inc       one-cycle pulse on acceptance
//   o_rw           register-file strobe: 1 read/hold, 0 write rd
//   o_rs1/o_rs2/o_rd  register addresses IR[1:0], IR[3:2], IR[5:4]
//   o_alu_op       0 AND, 1 OR, 2 ADD/SUB, 3 SLT
//   o_binv/o_cin   invert-B and carry-in
//   o_wb_sel       0 ALU result, 1 immediate
//   o_imm          IR[11:8]
//   o_busy         high in DECODE, EXEC, WB
//   o_halted       high in HALT
//   o_illegal      one-cycle pulse in EXEC for an undefined encoding
//   o_retired_cnt  instructions completed through WB (wraps)

module cpu_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_instr_valid,
    input  logic [15:0]      i_instr,
    output logic             o_instr_ready,
    output logic             o_pc_inc,
    output logic             o_rw,
    output logic [1:0]       o_rs1,
    output logic [1:0]       o_rs2,
    output logic [1:0]       o_rd,
    output logic [1:0]       o_alu_op,
    output logic             o_binv,
    output logic             o_cin,
    output logic             o_wb_sel,
    output logic [3:0]       o_imm,
    output logic             o_busy,
    output logic             o_halted,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_retired_cnt
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt
    } state_e;

    localparam logic [3:0] ClassAlu  = 4'h0;
    localparam logic [3:0] ClassLi   = 4'h1;
    localparam logic [3:0] ClassHalt = 4'hF;

    state_e      r_state;
    state_e      w_state_next;
    logic [15:0] r_ir;

    logic        w_accept;
    logic [3:0]  w_class;
    logic [2:0]  w_funct;
    logic        w_is_rtype;
    logic        w_is_li;
    logic        w_is_halt;
    logic        w_funct_ok;
    logic        w_illegal_instr;
    logic [1:0]  w_dec_alu_op;
    logic        w_dec_binv;
    logic        w_dec_cin;

    // Ready is gated by rst so nothing can be accepted on a reset edge.
    assign w_accept = (r_state == StFetch) && !rst && i_instr_valid;

    // ------------------------------------------------------------------
    // State and instruction registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir <= '0;
        end else if (w_accept) begin
            r_ir <= i_instr;
        end
    end

    // ------------------------------------------------------------------
    // Instruction decode (from the registered IR)
    // ------------------------------------------------------------------
    assign w_class    = r_ir[15:12];
    assign w_funct    = r_ir[8:6];
    assign w_is_rtype = (w_class == ClassAlu);
    assign w_is_li    = (w_class == ClassLi);
    assign w_is_halt  = (w_class == ClassHalt);

    always_comb begin
        w_dec_alu_op = 2'd0;
        w_dec_binv   = 1'b0;
        w_dec_cin    = 1'b0;
        w_funct_ok   = 1'b1;
        case (w_funct)
            3'b000: w_dec_alu_op = 2'd0;
            3'b001: w_dec_alu_op = 2'd1;
            3'b010: w_dec_alu_op = 2'd2;
            3'b011: begin
                w_dec_alu_op = 2'd2;
                w_dec_binv   = 1'b1;
                w_dec_cin    = 1'b1;
            end
            3'b111: begin
                w_dec_alu_op = 2'd3;
                w_dec_binv   = 1'b1;
                w_dec_cin    = 1'b1;
            end
            default: w_funct_ok = 1'b0;
        endcase
    end

    assign w_illegal_instr = !((w_is_rtype && w_funct_ok) || w_is_li || w_is_halt);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StFetch:  if (w_accept) w_state_next = StDecode;
            StDecode: w_state_next = StExec;
            StExec: begin
                if (w_is_halt) begin
                    w_state_next = StHalt;
                end else if (w_illegal_instr) begin
                    w_state_next = StFetch;
                end else begin
                    w_state_next = StWb;
                end
            end
            StWb:     w_state_next = StFetch;
            StHalt:   w_state_next = StHalt;
            default:  w_state_next = StFetch;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_instr_ready = (r_state == StFetch) && !rst;
        o_pc_inc      = w_accept;
        // The register file writes whenever rw is low, so only WB may drive 0.
        o_rw          = (r_state != StWb);
        o_busy        = (r_state == StDecode) || (r_state == StExec) || (r_state == StWb);
        o_halted      = (r_state == StHalt);
        o_illegal     = (r_state == StExec) && w_illegal_instr;
        // ALU controls are only meaningful for R-type; other classes see AND/0/0.
        o_alu_op      = w_is_rtype ? w_dec_alu_op : 2'd0;
        o_binv        = w_is_rtype && w_dec_binv;
        o_cin         = w_is_rtype && w_dec_cin;
        o_wb_sel      = w_is_li;
        o_rs1         = r_ir[1:0];
        o_rs2         = r_ir[3:2];
        o_rd          = r_ir[5:4];
        o_imm         = r_ir[11:8];
    end

`ifdef CPU_CTRL_PERF_EN
    logic [CNT_W-1:0] r_retired_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_cnt <= '0;
        end else if (r_state == StWb) begin
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
        end
    end

    assign o_retired_cnt = r_retired_cnt;
`else
    assign o_retired_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Testbench for cpu_ctrl: table of instructions with expected decode results,
// scoreboard queue pushed on acceptance and popped at the outcome cycle, plus
// hand-written back-to-back, reset-mid-instruction and HALT sequences.

module tb_cpu_ctrl;

`ifdef CPU_CTRL_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    localparam int KindNormal  = 0;
    localparam int KindIllegal = 1;
    localparam int KindHalt    = 2;

    typedef struct {
        logic [15:0] instr;
        int          kind;
        int          chk_alu;
        int          alu_op;
        int          binv;
        int          cin;
        int          wb_sel;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_instr_valid = 1'b0;
    logic [15:0] i_instr = 16'h0;
    logic        o_instr_ready;
    logic        o_pc_inc;
    logic        o_rw;
    logic [1:0]  o_rs1;
    logic [1:0]  o_rs2;
    logic [1:0]  o_rd;
    logic [1:0]  o_alu_op;
    logic        o_binv;
    logic        o_cin;
    logic        o_wb_sel;
    logic [3:0]  o_imm;
    logic        o_busy;
    logic        o_halted;
    logic        o_illegal;
    logic [7:0]  o_retired_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int model_cnt = 0;
    vec_t sb[$];
    vec_t vecs[$];

    cpu_ctrl #(.CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_instr_valid (i_instr_valid),
        .i_instr       (i_instr),
        .o_instr_ready (o_instr_ready),
        .o_pc_inc      (o_pc_inc),
        .o_rw          (o_rw),
        .o_rs1         (o_rs1),
        .o_rs2         (o_rs2),
        .o_rd          (o_rd),
        .o_alu_op      (o_alu_op),
        .o_binv        (o_binv),
        .o_cin         (o_cin),
        .o_wb_sel      (o_wb_sel),
        .o_imm         (o_imm),
        .o_busy        (o_busy),
        .o_halted      (o_halted),
        .o_illegal     (o_illegal),
        .o_retired_cnt (o_retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int exp_cnt();
        return PerfEn ? (model_cnt % 256) : 0;
    endfunction

    function automatic vec_t mk(input logic [15:0] instr, input int kind, input int chk_alu,
                                input int alu_op, input int binv, input int cin,
                                input int wb_sel);
        vec_t v;
        v.instr = instr; v.kind = kind; v.chk_alu = chk_alu;
        v.alu_op = alu_op; v.binv = binv; v.cin = cin; v.wb_sel = wb_sel;
        return v;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, o_instr_ready, 1);
        chk({tag, "_rw"}, o_rw, 1);
        chk({tag, "_pc_inc"}, o_pc_inc, 0);
        chk({tag, "_alu_op"}, o_alu_op, 0);
        chk({tag, "_binv_cin"}, {o_binv, o_cin}, 0);
        chk({tag, "_wb_sel"}, o_wb_sel, 0);
        chk({tag, "_busy_halt_ill"}, {o_busy, o_halted, o_illegal}, 0);
        chk({tag, "_retired"}, o_retired_cnt, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        i_instr_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready_low", o_instr_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        chk_reset_vals("reset");
    endtask

    task automatic chk_fields(input string tag, input vec_t v);
        logic [15:0] w;
        w = v.instr;
        chk({tag, "_rs1"}, o_rs1, int'(w[1:0]));
        chk({tag, "_rs2"}, o_rs2, int'(w[3:2]));
        chk({tag, "_rd"}, o_rd, int'(w[5:4]));
        chk({tag, "_imm"}, o_imm, int'(w[11:8]));
        if (v.chk_alu != 0) begin
            chk({tag, "_alu_op"}, o_alu_op, v.alu_op);
            chk({tag, "_binv"}, o_binv, v.binv);
            chk({tag, "_cin"}, o_cin, v.cin);
        end
    endtask

    task automatic pop_exp(output vec_t e, output bit ok);
        ok = (sb.size() != 0);
        if (!ok) chk("scoreboard_empty", 0, 1);
        else e = sb.pop_front();
    endtask

    task automatic run_vec(input vec_t v);
        bit   acc;
        bit   ok;
        vec_t e;
        acc = 0;
        @(posedge clk); #1;
        i_instr_valid = 1'b1;
        i_instr = v.instr;
        for (int k = 0; k < 10 && !acc; k++) begin
            @(negedge clk);
            if (o_instr_ready) begin
                acc = 1;
                chk("pc_inc_on_accept", o_pc_inc, 1);
                sb.push_back(v);
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            i_instr_valid = 1'b0;
            return;
        end
        // Junk on the bus after acceptance must not disturb the latched IR.
        @(posedge clk); #1;
        i_instr_valid = 1'b0;
        i_instr = 16'($urandom);
        // Cycle N+1: DECODE
        @(negedge clk);
        chk("dec_rw", o_rw, 1);
        chk("dec_busy", o_busy, 1);
        chk("dec_ready_pc", {o_instr_ready, o_pc_inc}, 0);
        chk("dec_illegal", o_illegal, 0);
        chk_fields("dec", v);
        // Cycle N+2: EXEC
        @(posedge clk); #1;
        @(negedge clk);
        chk("exec_rw", o_rw, 1);
        chk("exec_illegal", o_illegal, (v.kind == KindIllegal) ? 1 : 0);
        if (v.kind == KindIllegal) pop_exp(e, ok);
        // Cycle N+3
        @(posedge clk); #1;
        @(negedge clk);
        if (v.kind == KindNormal) begin
            pop_exp(e, ok);
            chk("wb_rw", o_rw, 0);
            if (ok) begin
                chk("wb_sel", o_wb_sel, e.wb_sel);
                chk_fields("wb", e);
            end
            model_cnt++;
            @(posedge clk); #1;
            @(negedge clk);
            chk("post_wb_ready", o_instr_ready, 1);
            chk("post_wb_rw", o_rw, 1);
            chk("retired", o_retired_cnt, exp_cnt());
        end else if (v.kind == KindIllegal) begin
            chk("ill_back_to_fetch", o_instr_ready, 1);
            chk("ill_no_write", o_rw, 1);
            chk("ill_pulse_once", o_illegal, 0);
            chk("ill_retired", o_retired_cnt, exp_cnt());
        end else begin
            pop_exp(e, ok);
            chk("halt_halted", o_halted, 1);
            chk("halt_ready", o_instr_ready, 0);
            chk("halt_rw_busy", {o_rw, o_busy}, 2);
        end
    endtask

    initial begin
        int   acc_cyc[2];
        int   n_acc;
        int   n_wb;
        bit   ok;
        vec_t e;
        vec_t v_sub;
        vec_t v_slt;

        vecs.push_back(mk(16'h0096, KindNormal, 1, 2, 0, 0, 0));  // ADD
        vecs.push_back(mk(16'h00E7, KindNormal, 1, 2, 1, 1, 0));  // SUB
        vecs.push_back(mk(16'h01C4, KindNormal, 1, 3, 1, 1, 0));  // SLT
        vecs.push_back(mk(16'h001B, KindNormal, 1, 0, 0, 0, 0));  // AND
        vecs.push_back(mk(16'h0079, KindNormal, 1, 1, 0, 0, 0));  // OR
        vecs.push_back(mk(16'h1A20, KindNormal, 0, 0, 0, 0, 1));  // LI
        vecs.push_back(mk(16'h0140, KindIllegal, 0, 0, 0, 0, 0)); // funct 101
        vecs.push_back(mk(16'h0180, KindIllegal, 0, 0, 0, 0, 0)); // funct 110
        vecs.push_back(mk(16'h2000, KindIllegal, 0, 0, 0, 0, 0)); // class 2
        vecs.push_back(mk(16'h7123, KindIllegal, 0, 0, 0, 0, 0)); // class 7
        vecs.push_back(mk(16'h0096, KindNormal, 1, 2, 0, 0, 0));  // ADD again

        // Reset held for two cycles.
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready_low0", o_instr_ready, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset0");

        foreach (vecs[i]) run_vec(vecs[i]);

        // SUB then SLT back-to-back with valid held high.
        v_sub = vecs[1];
        v_slt = vecs[2];
        n_acc = 0;
        n_wb = 0;
        @(posedge clk); #1;
        i_instr_valid = 1'b1;
        i_instr = v_sub.instr;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (!o_rw) begin
                n_wb++;
                model_cnt++;
                pop_exp(e, ok);
                if (ok) chk_fields("b2b_wb", e);
            end
            if (o_pc_inc) begin
                if (n_acc < 2) acc_cyc[n_acc] = c;
                sb.push_back(n_acc == 0 ? v_sub : v_slt);
                n_acc++;
            end
            @(posedge clk); #1;
            if (n_acc == 1) i_instr = v_slt.instr;
            if (n_acc >= 2) i_instr_valid = 1'b0;
        end
        i_instr_valid = 1'b0;
        chk("b2b_accepts", n_acc, 2);
        chk("b2b_writes", n_wb, 2);
        if (n_acc == 2) chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], 4);
        @(negedge clk);
        chk("b2b_retired", o_retired_cnt, exp_cnt());

        // Reset asserted during DECODE of an ADD.
        @(posedge clk); #1;
        i_instr_valid = 1'b1;
        i_instr = 16'h0096;
        @(negedge clk);
        chk("rstmid_accept", {o_instr_ready, o_pc_inc}, 3);
        @(posedge clk); #1;
        i_instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ready_low", o_instr_ready, 0);
        chk("rstmid_dec_rw", o_rw, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rstmid_no_write", o_rw, 1);
            chk("rstmid_fetch", {o_instr_ready, o_busy}, 2);
            chk("rstmid_retired", o_retired_cnt, 0);
            @(posedge clk); #1;
        end

        // Give the counter something to hold across HALT.
        run_vec(vecs[0]);
        run_vec(mk(16'h0100, KindIllegal, 0, 0, 0, 0, 0));
        run_vec(mk(16'hF000, KindHalt, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        i_instr_valid = 1'b1;
        i_instr = 16'h0096;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("halt_stays", {o_halted, o_instr_ready, o_pc_inc, o_rw}, 4'b1001);
            chk("halt_retired", o_retired_cnt, exp_cnt());
            @(posedge clk); #1;
        end
        do_reset();
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
